p2_dac_packer: RTL and testbench

P2_DAC_PACKER -- requirements
Module: p2_dac_packer

---
 rtl/p2_dac_packer.sv | 120 ++++++++++++
 tb/tb_p2_dac_packer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/p2_dac_packer.sv
// Sign-magnitude sample-pair to offset-binary packer feeding a show-ahead FIFO toward a DAC.
// Latency: pair accepted at edge N appears on out_word after edge N+1 when the FIFO is empty.
// Backpressure: none upstream; when the FIFO is full and not being read, the staged word is dropped and overflow is set.
//
// Ports:
//   clk, resetn                 - sole clock, asynchronous active-low reset
//   in_valid, in_val_0/1        - sample pair input (sign-magnitude, bit7 = sign)
//   out_ready, out_valid        - valid/ready handshake on the packed output
//   out_word                    - {conv(in_val_0), conv(in_val_1)} in offset binary
//   fifo_count                  - number of words held in the FIFO
//   overflow, clr_overflow      - sticky drop flag and its synchronous clear
module p2_dac_packer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  input  logic [7:0]                    in_val_0,
  input  logic [7:0]                    in_val_1,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [15:0]                   out_word,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  // Sign-magnitude to offset binary: 128 + m for positive, 128 - m for negative.
  // Negative zero collapses onto the same code as positive zero (0x80).
  function automatic logic [7:0] sm_to_ob(input logic [7:0] v);
    logic [7:0] mag;
    mag = {1'b0, v[6:0]};
    if (v[7]) begin
      return 8'h80 - mag;
    end
    return 8'h80 + mag;
  endfunction

  logic              stage_valid_q, stage_valid_d;
  logic [15:0]       stage_word_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       mem_q [FIFO_DEPTH];

  logic full;
  logic do_rd;
  logic do_wr;
  logic drop;

  assign out_valid  = (count_q != '0);
  assign out_word   = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  assign full  = (count_q == DEPTH_C);
  assign do_rd = out_valid && out_ready;
  // When full, a concurrent read frees the slot at wr_ptr (== rd_ptr), so the
  // write may land in the same slot being read out this cycle.
  assign do_wr = stage_valid_q && (!full || do_rd);
  assign drop  = stage_valid_q && full && !do_rd;

  always_comb begin
    stage_valid_d = in_valid;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;

    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_wr && !do_rd) begin
      count_d = count_q + 1'b1;
    end else if (do_rd && !do_wr) begin
      count_d = count_q - 1'b1;
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage_valid_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
    end
  end

  // Data path carries no reset: contents are only observed behind valid flags.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      stage_word_q <= {sm_to_ob(in_val_0), sm_to_ob(in_val_1)};
    end
    if (do_wr) begin
      mem_q[wr_ptr_q] <= stage_word_q;
    end
  end

endmodule

// File: tb/tb_p2_dac_packer.sv
module tb_p2_dac_packer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [7:0]  in_val_0;
  logic [7:0]  in_val_1;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_word;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        clr_overflow;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  p2_dac_packer #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_val_0(in_val_0),
    .in_val_1(in_val_1), .out_ready(out_ready), .out_valid(out_valid),
    .out_word(out_word), .fifo_count(fifo_count), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  // Reference conversion straight from the arithmetic definition.
  function automatic logic [15:0] ref_word(input int a, input int b);
    int ca, cb;
    ca = (a >= 128) ? 128 - (a - 128) : 128 + a;
    cb = (b >= 128) ? 128 - (b - 128) : 128 + b;
    return 16'(ca * 256 + cb);
  endfunction

  task automatic set_idle();
    in_valid = 1'b0; in_val_0 = 8'h00; in_val_1 = 8'h00;
    out_ready = 1'b0; clr_overflow = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
  endtask

  // Drive a random pair for one edge and record its expected packed word.
  task automatic send_rand(input bit record);
    logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    in_valid = 1'b1; in_val_0 = a; in_val_1 = b;
    if (record) exp_q.push_back(ref_word(int'(a), int'(b)));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_idle();
    resetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_conversion();
    do_reset();
    in_valid = 1'b1; in_val_0 = 8'h7F; in_val_1 = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL conv_early_valid got %b exp 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL conv_valid got %b exp 1", out_valid); end
    checks++; if (out_word !== 16'hFF01) begin errors++; $display("FAIL conv_word got %h exp ff01", out_word); end
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL conv_count got %0d exp 1", fifo_count); end
    // Random burst of back-to-back pairs, then drain against the model.
    do_reset();
    for (int i = 0; i < 6; i++) send_rand(1'b1);
    @(negedge clk);
    checks++; if (fifo_count !== 4'd6) begin errors++; $display("FAIL burst_count got %0d exp 6", fifo_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_word !== exp_q[0]) begin
        errors++; $display("FAIL burst_word%0d got %b/%h exp 1/%h", i, out_valid, out_word, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL burst_empty got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_zero();
    do_reset();
    // out_ready held high on an empty FIFO must not cause a read.
    out_ready = 1'b1;
    in_valid = 1'b1; in_val_0 = 8'h00; in_val_1 = 8'h80;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got %b exp 1", out_valid); end
    checks++; if (out_word !== 16'h8080) begin errors++; $display("FAIL zero_word got %h exp 8080", out_word); end
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL zero_count got %0d exp 1", fifo_count); end
    @(negedge clk);
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL zero_drain got %0d exp 0", fifo_count); end
    out_ready = 1'b0;
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) send_rand(i < 8);
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d exp 8", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_early_ovf got %b exp 0", overflow); end
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got %b exp 1", overflow); end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_count_after_drop got %0d exp 8", fifo_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_word !== exp_q[0]) begin
        errors++; $display("FAIL fill_word%0d got %b/%h exp 1/%h", i, out_valid, out_word, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_extra_word got %b exp 0", out_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_sticky got %b exp 1", overflow); end
    out_ready = 1'b0;
  endtask

  task automatic test_clr_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) send_rand(1'b0);
    @(negedge clk);
    send_rand(1'b0);
    // Stage holds a word, FIFO is full, no read: drop coincides with clear.
    clr_overflow = 1'b1;
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_set_wins got %b exp 1", overflow); end
    @(negedge clk);
    clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_clears got %b exp 0", overflow); end
  endtask

  task automatic test_full_concurrent_read();
    do_reset();
    for (int i = 0; i < 8; i++) send_rand(1'b1);
    @(negedge clk);
    send_rand(1'b1);
    // Stage valid, FIFO full, read in the same edge.
    out_ready = 1'b1;
    checks++; if (out_word !== exp_q[0]) begin errors++; $display("FAIL fcr_first got %h exp %h", out_word, exp_q[0]); end
    void'(exp_q.pop_front());
    @(negedge clk);
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fcr_count got %0d exp 8", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fcr_ovf got %b exp 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_word !== exp_q[0]) begin
        errors++; $display("FAIL fcr_word%0d got %b/%h exp 1/%h", i, out_valid, out_word, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fcr_empty got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_stream_wrap();
    int sent, got, cyc, cnt_bad, inflight;
    bit rdy;
    logic [7:0] a, b;
    do_reset();
    sent = 0; got = 0; cyc = 0; cnt_bad = 0;
    while (got < 40 && cyc < 3000) begin
      if (fifo_count > 4'd8) cnt_bad++;
      rdy = ($urandom_range(0, 3) != 0);
      if (out_valid && rdy) begin
        checks++;
        if (exp_q.size() == 0 || out_word !== exp_q[0]) begin
          errors++; $display("FAIL stream_word%0d got %h exp %h", got, out_word, (exp_q.size() != 0) ? exp_q[0] : 16'hxxxx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      out_ready = rdy;
      inflight = sent - got;
      if (sent < 40 && inflight < 8 && $urandom_range(0, 1) == 1) begin
        a = 8'($urandom); b = 8'($urandom);
        in_valid = 1'b1; in_val_0 = a; in_val_1 = b;
        exp_q.push_back(ref_word(int'(a), int'(b)));
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (got != 40) begin errors++; $display("FAIL stream_timeout got %0d words exp 40", got); end
    checks++; if (cnt_bad != 0) begin errors++; $display("FAIL stream_count_bound got %0d violations exp 0", cnt_bad); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stream_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] w;
    do_reset();
    for (int i = 0; i < 9; i++) send_rand(1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    send_rand(1'b0);
    checks++; if (fifo_count !== 4'd5 || overflow !== 1'b1) begin
      errors++; $display("FAIL mid_pre got %0d/%b exp 5/1", fifo_count, overflow);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b exp 0", overflow); end
    @(negedge clk);
    resetn = 1'b1;
    in_val_0 = 8'h85; in_val_1 = 8'h12; in_valid = 1'b1;
    w = ref_word(int'(8'h85), int'(8'h12));
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stage_leak got %b exp 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_word !== w || fifo_count !== 4'd1) begin
      errors++; $display("FAIL mid_first got %b/%h/%0d exp 1/%h/1", out_valid, out_word, fifo_count, w);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got %b exp 0", out_valid); end
  endtask

  initial begin
    set_idle();
    resetn = 1'b1;
    test_reset();
    test_conversion();
    test_zero();
    test_fill_overflow();
    test_clr_overflow();
    test_full_concurrent_read();
    test_stream_wrap();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
